// File: rtl/output_limit_ctrl.sv
// Output-limit controller: converts VCR grant pulses into bounded FIFO read
// windows for the high-speed interface, or passes reads through when unlimited.
module output_limit_ctrl #(
    parameter int unsigned PENDING_WIDTH = 20,
    parameter int unsigned MAX_LIMIT     = 16'hFFFF
) (
    input  logic        IFCLK,
    input  logic        RESET_N,
    input  logic        output_mode_limit,
    input  logic        reg_output_limit,
    input  logic        wr_word,
    input  logic        hs_rd_req,
    input  logic        fifo_empty,
    output logic        hs_rd_en,
    output logic [15:0] output_limit,
    output logic        output_limit_not_done,
    output logic        pending_overflow
);

    localparam int unsigned PW = PENDING_WIDTH;
    // Wide enough for pending + remaining + wr_word without wrap
    localparam int unsigned SW = ((PW > 16) ? PW : 16) + 2;
    localparam logic [SW-1:0] PEND_MAX = (SW'(1) << PW) - SW'(1);
    localparam logic [SW-1:0] LIM_MAX  = SW'(MAX_LIMIT);

    typedef enum logic [1:0] {
        UNLIMITED = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pending, pending_nxt;
    logic [15:0]     remaining, remaining_nxt;
    logic [15:0]     output_limit_nxt;
    logic            overflow_nxt;
    logic [SW-1:0]   pend_ext, wr_ext, rd_ext, rem_ext, grant, sum;

    assign hs_rd_en = hs_rd_req & ~fifo_empty & ((state == UNLIMITED) | (remaining != 16'd0));

    assign pend_ext = SW'(pending);
    assign wr_ext   = SW'(wr_word);
    assign rd_ext   = SW'(hs_rd_en);
    assign rem_ext  = SW'(remaining);
    assign grant    = (pend_ext > LIM_MAX) ? LIM_MAX : pend_ext;

    // Next-state and counter update; mode changes win over registration
    always_comb begin
        state_nxt        = state;
        remaining_nxt    = remaining;
        output_limit_nxt = output_limit;
        sum              = pend_ext + wr_ext;
        case (state)
            UNLIMITED: begin
                sum = (pend_ext + wr_ext < rd_ext) ? '0 : pend_ext + wr_ext - rd_ext;
                if (output_mode_limit) state_nxt = IDLE;
            end
            IDLE: begin
                if (!output_mode_limit) begin
                    state_nxt = UNLIMITED;
                end else if (reg_output_limit) begin
                    output_limit_nxt = 16'(grant);
                    remaining_nxt    = 16'(grant);
                    sum              = pend_ext - grant + wr_ext;
                    if (grant != '0) state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!output_mode_limit) begin
                    // Granted-but-unread words go back to the pending pool
                    sum           = pend_ext + rem_ext + wr_ext - rd_ext;
                    remaining_nxt = 16'd0;
                    state_nxt     = UNLIMITED;
                end else begin
                    remaining_nxt = remaining - 16'(hs_rd_en);
                    if (reg_output_limit) output_limit_nxt = remaining;
                    if (remaining_nxt == 16'd0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        pending_nxt  = (sum > PEND_MAX) ? PW'(PEND_MAX) : PW'(sum);
        overflow_nxt = pending_overflow | (wr_word & (sum > PEND_MAX));
    end

    always_ff @(posedge IFCLK) begin
        if (!RESET_N) begin
            state                 <= output_mode_limit ? IDLE : UNLIMITED;
            pending               <= '0;
            remaining             <= 16'd0;
            output_limit          <= 16'd0;
            output_limit_not_done <= 1'b0;
            pending_overflow      <= 1'b0;
        end else begin
            state                 <= state_nxt;
            pending               <= pending_nxt;
            remaining             <= remaining_nxt;
            output_limit          <= output_limit_nxt;
            output_limit_not_done <= (remaining_nxt != 16'd0);
            pending_overflow      <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_output_limit_ctrl.sv
// Directed bench for output_limit_ctrl: default instance plus a narrow
// instance (4-bit pending, 10-word cap) for saturation and capping.
module tb_output_limit_ctrl;

    logic        ifclk = 1'b0;
    logic        reset_n, mode, reg_lim, wr_word, rd_req, fifo_empty;
    logic        rd_en, not_done, ovf;
    logic [15:0] olim;
    logic        rd_en_s, not_done_s, ovf_s;
    logic [15:0] olim_s;
    int          checks = 0;
    int          errors = 0;
    int          cnt;

    always #5 ifclk = ~ifclk;

    output_limit_ctrl dut (
        .IFCLK(ifclk), .RESET_N(reset_n), .output_mode_limit(mode),
        .reg_output_limit(reg_lim), .wr_word(wr_word), .hs_rd_req(rd_req),
        .fifo_empty(fifo_empty), .hs_rd_en(rd_en), .output_limit(olim),
        .output_limit_not_done(not_done), .pending_overflow(ovf)
    );

    output_limit_ctrl #(.PENDING_WIDTH(4), .MAX_LIMIT(10)) dut_s (
        .IFCLK(ifclk), .RESET_N(reset_n), .output_mode_limit(mode),
        .reg_output_limit(reg_lim), .wr_word(wr_word), .hs_rd_req(rd_req),
        .fifo_empty(fifo_empty), .hs_rd_en(rd_en_s), .output_limit(olim_s),
        .output_limit_not_done(not_done_s), .pending_overflow(ovf_s)
    );

    task automatic tick();
        @(posedge ifclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; mode = 1'b1; reg_lim = 1'b0; wr_word = 1'b0;
        rd_req = 1'b0; fifo_empty = 1'b0;
        ticks(2);
        rd_req = 1'b1; #1;
        check("rst_olim", 32'(olim), 0);
        check("rst_notdone", 32'(not_done), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_idle_rden", 32'(rd_en), 0);
        rd_req = 1'b0;
        reset_n = 1'b1;

        // Basic grant of 10 words
        wr_word = 1'b1; ticks(10); wr_word = 1'b0;
        reg_lim = 1'b1; tick(); reg_lim = 1'b0;
        check("g10_olim", 32'(olim), 10);
        check("g10_notdone", 32'(not_done), 1);
        rd_req = 1'b1; cnt = 0;
        for (int i = 0; i < 15; i++) begin
            #1; if (rd_en) cnt++;
            tick();
        end
        rd_req = 1'b0;
        check("g10_reads", 32'(cnt), 10);
        check("g10_notdone_end", 32'(not_done), 0);
        check("g10_pending", 32'(dut.pending), 0);

        // Write coincident with registration lands in pending
        wr_word = 1'b1; ticks(5);
        reg_lim = 1'b1; tick(); reg_lim = 1'b0; wr_word = 1'b0;
        check("coinc_olim", 32'(olim), 5);
        check("coinc_pending", 32'(dut.pending), 1);
        rd_req = 1'b1; ticks(5); rd_req = 1'b0;
        check("coinc_notdone", 32'(not_done), 0);

        // Refused registration while active
        wr_word = 1'b1; ticks(4); wr_word = 1'b0;
        reg_lim = 1'b1; tick(); reg_lim = 1'b0;
        check("ref_olim_grant", 32'(olim), 5);
        rd_req = 1'b1; ticks(2); rd_req = 1'b0;
        reg_lim = 1'b1; tick(); reg_lim = 1'b0;
        check("ref_olim", 32'(olim), 3);
        check("ref_pending", 32'(dut.pending), 0);
        check("ref_notdone", 32'(not_done), 1);
        rd_req = 1'b1; ticks(3); rd_req = 1'b0;
        check("ref_done", 32'(not_done), 0);
        reg_lim = 1'b1; tick(); reg_lim = 1'b0;
        check("zero_olim", 32'(olim), 0);
        check("zero_notdone", 32'(not_done), 0);

        // Mode drop mid-transfer returns unread words
        wr_word = 1'b1; ticks(6); wr_word = 1'b0;
        reg_lim = 1'b1; tick(); reg_lim = 1'b0;
        rd_req = 1'b1; ticks(2); rd_req = 1'b0;
        wr_word = 1'b1; ticks(2); wr_word = 1'b0;
        mode = 1'b0; tick();
        check("drop_pending", 32'(dut.pending), 6);
        check("drop_notdone", 32'(not_done), 0);
        rd_req = 1'b1; #1;
        check("unl_rden", 32'(rd_en), 1);
        fifo_empty = 1'b1; #1;
        check("unl_empty_rden", 32'(rd_en), 0);
        fifo_empty = 1'b0;
        ticks(3);
        check("unl_pending_rd", 32'(dut.pending), 3);
        wr_word = 1'b1; tick(); wr_word = 1'b0;
        check("unl_wr_rd", 32'(dut.pending), 3);
        rd_req = 1'b0;
        reg_lim = 1'b1; tick(); reg_lim = 1'b0;
        check("unl_reg_ignored", 32'(olim), 6);
        rd_req = 1'b1; ticks(5); rd_req = 1'b0;
        check("unl_floor", 32'(dut.pending), 0);
        mode = 1'b1; tick();
        rd_req = 1'b1; #1;
        check("back_idle_rden", 32'(rd_en), 0);
        rd_req = 1'b0;

        // Grant capped at 65535
        wr_word = 1'b1; ticks(70000); wr_word = 1'b0;
        check("big_pending", 32'(dut.pending), 70000);
        reg_lim = 1'b1; tick(); reg_lim = 1'b0;
        check("big_olim", 32'(olim), 65535);
        check("big_pending_left", 32'(dut.pending), 4465);
        check("big_notdone", 32'(not_done), 1);

        // Reset mid-transfer discards everything
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("mid_rst_olim", 32'(olim), 0);
        check("mid_rst_notdone", 32'(not_done), 0);
        check("mid_rst_pending", 32'(dut.pending), 0);
        rd_req = 1'b1; #1;
        check("mid_rst_rden", 32'(rd_en), 0);
        rd_req = 1'b0;

        // Narrow instance: saturation and capped re-grant
        wr_word = 1'b1; ticks(16); wr_word = 1'b0;
        check("sat_pending", 32'(dut_s.pending), 15);
        check("sat_ovf", 32'(ovf_s), 1);
        reg_lim = 1'b1; tick(); reg_lim = 1'b0;
        check("cap_olim", 32'(olim_s), 10);
        check("cap_pending", 32'(dut_s.pending), 5);
        rd_req = 1'b1; cnt = 0;
        for (int i = 0; i < 12; i++) begin
            #1; if (rd_en_s) cnt++;
            tick();
        end
        rd_req = 1'b0;
        check("cap_reads", 32'(cnt), 10);
        check("cap_notdone", 32'(not_done_s), 0);
        reg_lim = 1'b1; tick(); reg_lim = 1'b0;
        check("regrant_olim", 32'(olim_s), 5);
        check("ovf_sticky", 32'(ovf_s), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
